// File: rtl/sync_fifo_ext_pkg.sv
// sync_fifo_ext shared types.
// Read-mode enum and count-width helper.
package sync_fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // FWFT holds one word beyond the RAM depth.
  function automatic int cnt_width(input int aw);
    return $clog2((2 ** aw) + 2);
  endfunction

endpackage

// File: rtl/sync_fifo_ext_sdp_ram.sv
// Simple dual-port RAM, one write port,
// synchronous read into a resettable hold register.
module sdp_ram #(
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter bit BLOCK = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] rd_word;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rdata_d;

  if (BLOCK) begin : g_block
    (* ram_style = "block" *)
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
      if (we) begin
        mem[waddr] <= wdata;
      end
    end

    assign rd_word = mem[raddr];
  end else begin : g_dist
    (* ram_style = "distributed" *)
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
      if (we) begin
        mem[waddr] <= wdata;
      end
    end

    assign rd_word = mem[raddr];
  end

  // Holds the last word read when no load occurs.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with STD / FWFT read modes,
// occupancy count, threshold flags and error pulses.
module sync_fifo_ext
  import sync_fifo_pkg::*;
#(
  parameter int         ADDR_WIDTH = 8,
  parameter int         DATA_WIDTH = 8,
  parameter fifo_mode_e MODE       = FIFO_STD,
  parameter int         AF_THRESH  = 2**ADDR_WIDTH - 2,
  parameter int         AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int AW = ADDR_WIDTH;
  localparam int CW = cnt_width(ADDR_WIDTH);
  localparam logic [CW-1:0] AF_C = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C = CW'(AE_THRESH);
  localparam logic [AW:0]   PZ   = '0;
  localparam logic [CW-1:0] C1   = CW'(1);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic ram_empty;
  logic ram_full;
  logic wr_acc;
  logic load;
  logic pop;

  assign ram_empty = (wr_ptr_q == rd_ptr_q);
  assign ram_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_acc    = wr_en && !ram_full && !rst;

  always_comb begin
    load    = 1'b0;
    pop     = 1'b0;
    valid_d = valid_q;
    unf_d   = 1'b0;
    if (MODE == FIFO_FWFT) begin
      // Refill the output register whenever it is free or being popped.
      load  = !ram_empty && (!valid_q || rd_en);
      pop   = rd_en && valid_q;
      unf_d = rd_en && !valid_q;
      if (load) begin
        valid_d = 1'b1;
      end else if (pop) begin
        valid_d = 1'b0;
      end
    end else begin
      load    = rd_en && !ram_empty;
      pop     = load;
      unf_d   = rd_en && ram_empty;
      valid_d = load;
    end
  end

  always_comb begin
    ovf_d    = wr_en && ram_full;
    wr_ptr_d = wr_ptr_q + {PZ[AW:1], wr_acc};
    rd_ptr_d = rd_ptr_q + {PZ[AW:1], load};
    count_d  = count_q;
    if (wr_acc && !pop) begin
      count_d = count_q + C1;
    end else if (!wr_acc && pop) begin
      count_d = count_q - C1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  sdp_ram #(
    .AW    (AW),
    .DW    (DATA_WIDTH),
    .BLOCK (1'b1)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (wr_data),
    .re    (load),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rd_data)
  );

  assign rd_valid     = valid_q;
  assign full         = ram_full;
  assign empty        = (MODE == FIFO_FWFT) ? !valid_q : ram_empty;
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign data_count   = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Bench for sync_fifo_ext: STD and FWFT instances,
// directed scenarios plus a random queue-model run.
module tb_sync_fifo_ext;
  import sync_fifo_pkg::*;

  logic clk = 1'b0;
  logic rst;

  logic       s_wr, s_rd;
  logic [7:0] s_wd;
  logic [7:0] s_rdd;
  logic       s_rv, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic [2:0] s_cnt;

  logic       f_wr, f_rd;
  logic [7:0] f_wd;
  logic [7:0] f_rdd;
  logic       f_rv, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [2:0] f_cnt;

  logic [17:0] s_vec, f_vec;
  assign s_vec = {s_rdd, s_rv, s_full, s_empty, s_af, s_ae,
                  s_cnt, s_ovf, s_unf};
  assign f_vec = {f_rdd, f_rv, f_full, f_empty, f_af, f_ae,
                  f_cnt, f_ovf, f_unf};

  localparam logic [17:0] RST_VEC =
    {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0};

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sync_fifo_ext #(
    .ADDR_WIDTH (2),
    .DATA_WIDTH (8),
    .MODE       (FIFO_STD)
  ) u_std (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (s_wr),
    .wr_data      (s_wd),
    .rd_en        (s_rd),
    .rd_data      (s_rdd),
    .rd_valid     (s_rv),
    .full         (s_full),
    .empty        (s_empty),
    .almost_full  (s_af),
    .almost_empty (s_ae),
    .data_count   (s_cnt),
    .overflow     (s_ovf),
    .underflow    (s_unf)
  );

  sync_fifo_ext #(
    .ADDR_WIDTH (2),
    .DATA_WIDTH (8),
    .MODE       (FIFO_FWFT)
  ) u_fwft (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (f_wr),
    .wr_data      (f_wd),
    .rd_en        (f_rd),
    .rd_data      (f_rdd),
    .rd_valid     (f_rv),
    .full         (f_full),
    .empty        (f_empty),
    .almost_full  (f_af),
    .almost_empty (f_ae),
    .data_count   (f_cnt),
    .overflow     (f_ovf),
    .underflow    (f_unf)
  );

  // Reference model: STD is a 4-word queue; FWFT is a 4-word
  // queue behind a one-word presentation slot.
  logic [7:0] sq[$];
  logic [7:0] sm_d;
  logic       sm_v, sm_o, sm_u;

  logic [7:0] fq[$];
  logic [7:0] fm_d;
  logic       fm_v, fm_o, fm_u;

  task automatic model_std();
    bit e, fl;
    if (rst) begin
      sq.delete();
      sm_d = 8'h00; sm_v = 0; sm_o = 0; sm_u = 0;
    end else begin
      e  = (sq.size() == 0);
      fl = (sq.size() == 4);
      sm_o = s_wr && fl;
      sm_u = s_rd && e;
      sm_v = s_rd && !e;
      if (sm_v) sm_d = sq.pop_front();
      if (s_wr && !fl) sq.push_back(s_wd);
    end
  endtask

  task automatic model_fwft();
    bit fl, p;
    if (rst) begin
      fq.delete();
      fm_d = 8'h00; fm_v = 0; fm_o = 0; fm_u = 0;
    end else begin
      fl   = (fq.size() == 4);
      p    = f_rd && fm_v;
      fm_u = f_rd && !fm_v;
      fm_o = f_wr && fl;
      if (fq.size() > 0 && (!fm_v || f_rd)) begin
        fm_d = fq.pop_front();
        fm_v = 1;
      end else if (p) begin
        fm_v = 0;
      end
      if (f_wr && !fl) fq.push_back(f_wd);
    end
  endtask

  function automatic logic [17:0] exp_std();
    int n;
    n = sq.size();
    return {sm_d, sm_v, n == 4, n == 0, n >= 2, n <= 2,
            3'(n), sm_o, sm_u};
  endfunction

  function automatic logic [17:0] exp_fwft();
    int n;
    n = fq.size() + int'(fm_v);
    return {fm_d, fm_v, fq.size() == 4, !fm_v, n >= 2, n <= 2,
            3'(n), fm_o, fm_u};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_std();
    model_fwft();
    #1;
  endtask

  task automatic idle();
    s_wr = 0; s_rd = 0;
    f_wr = 0; f_rd = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    s_wr = 1; s_rd = 1; s_wd = 8'hFF;
    f_wr = 1; f_rd = 1; f_wd = 8'hFF;
    tick();
    rst = 0;
    idle();
    checks++;
    if (s_vec !== RST_VEC) begin
      failures++;
      $display("FAIL reset_std: got %h want %h", s_vec, RST_VEC);
    end
    checks++;
    if (f_vec !== RST_VEC) begin
      failures++;
      $display("FAIL reset_fwft: got %h want %h", f_vec, RST_VEC);
    end
  endtask

  task automatic test_std_fill();
    logic [7:0] w;
    for (int i = 0; i < 4; i++) begin
      s_wr = 1;
      s_wd = 8'(8'h11 * (i + 1));
      tick();
    end
    checks++;
    if (s_full !== 1'b1 || s_cnt !== 3'd4 || s_af !== 1'b1) begin
      failures++;
      $display("FAIL std_fill_flags: got full=%b cnt=%0d af=%b want 1 4 1",
               s_full, s_cnt, s_af);
    end
    s_wd = 8'h55;
    tick();
    s_wr = 0;
    checks++;
    if (s_ovf !== 1'b1 || s_cnt !== 3'd4) begin
      failures++;
      $display("FAIL std_overflow: got ovf=%b cnt=%0d want 1 4",
               s_ovf, s_cnt);
    end
    tick();
    checks++;
    if (s_ovf !== 1'b0) begin
      failures++;
      $display("FAIL std_ovf_pulse: got %b want 0", s_ovf);
    end
    for (int i = 0; i < 4; i++) begin
      s_rd = 1;
      tick();
      w = 8'(8'h11 * (i + 1));
      checks++;
      if (s_rv !== 1'b1 || s_rdd !== w) begin
        failures++;
        $display("FAIL std_read%0d: got v=%b d=%h want 1 %h",
                 i, s_rv, s_rdd, w);
      end
    end
    s_rd = 0;
    checks++;
    if (s_empty !== 1'b1 || s_cnt !== 3'd0) begin
      failures++;
      $display("FAIL std_drained: got empty=%b cnt=%0d want 1 0",
               s_empty, s_cnt);
    end
  endtask

  task automatic test_std_underflow();
    s_rd = 1; s_wr = 1; s_wd = 8'hA5;
    tick();
    s_wr = 0;
    checks++;
    if (s_unf !== 1'b1 || s_rv !== 1'b0 || s_cnt !== 3'd1) begin
      failures++;
      $display("FAIL std_underflow: got unf=%b v=%b cnt=%0d want 1 0 1",
               s_unf, s_rv, s_cnt);
    end
    tick();
    s_rd = 0;
    checks++;
    if (s_rv !== 1'b1 || s_rdd !== 8'hA5 || s_unf !== 1'b0) begin
      failures++;
      $display("FAIL std_after_unf: got v=%b d=%h unf=%b want 1 a5 0",
               s_rv, s_rdd, s_unf);
    end
  endtask

  task automatic test_fwft_single();
    f_wr = 1; f_wd = 8'h5A;
    tick();
    f_wr = 0;
    checks++;
    if (f_rv !== 1'b0) begin
      failures++;
      $display("FAIL fwft_latency_k: got v=%b want 0", f_rv);
    end
    tick();
    checks++;
    if (f_rv !== 1'b1 || f_rdd !== 8'h5A) begin
      failures++;
      $display("FAIL fwft_latency_k1: got v=%b d=%h want 1 5a",
               f_rv, f_rdd);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (f_rv !== 1'b1 || f_rdd !== 8'h5A || f_cnt !== 3'd1) begin
        failures++;
        $display("FAIL fwft_hold%0d: got v=%b d=%h cnt=%0d want 1 5a 1",
                 i, f_rv, f_rdd, f_cnt);
      end
    end
    f_rd = 1;
    tick();
    f_rd = 0;
    checks++;
    if (f_rv !== 1'b0 || f_empty !== 1'b1 || f_cnt !== 3'd0) begin
      failures++;
      $display("FAIL fwft_pop_last: got v=%b e=%b cnt=%0d want 0 1 0",
               f_rv, f_empty, f_cnt);
    end
  endtask

  task automatic test_fwft_fill();
    logic [7:0] w;
    for (int i = 0; i < 5; i++) begin
      f_wr = 1;
      f_wd = 8'(8'hA0 + i);
      tick();
    end
    f_wr = 0;
    checks++;
    if (f_full !== 1'b1 || f_cnt !== 3'd5 || f_rv !== 1'b1 ||
        f_rdd !== 8'hA0) begin
      failures++;
      $display("FAIL fwft_fill: got full=%b cnt=%0d v=%b d=%h want 1 5 1 a0",
               f_full, f_cnt, f_rv, f_rdd);
    end
    for (int i = 0; i < 5; i++) begin
      f_rd = 1;
      tick();
      w = 8'(8'hA1 + i);
      checks++;
      if (i < 4) begin
        if (f_rv !== 1'b1 || f_rdd !== w) begin
          failures++;
          $display("FAIL fwft_pop%0d: got v=%b d=%h want 1 %h",
                   i, f_rv, f_rdd, w);
        end
      end else if (f_rv !== 1'b0 || f_empty !== 1'b1) begin
        failures++;
        $display("FAIL fwft_pop_end: got v=%b e=%b want 0 1",
                 f_rv, f_empty);
      end
    end
    f_rd = 0;
  endtask

  task automatic test_full_rdwr();
    for (int i = 0; i < 5; i++) begin
      s_wr = (i < 4);
      s_wd = 8'(8'hB0 + i);
      f_wr = 1;
      f_wd = 8'(8'hC0 + i);
      tick();
    end
    s_wr = 1; s_rd = 1; s_wd = 8'hEE;
    f_wr = 1; f_rd = 1; f_wd = 8'hEE;
    tick();
    idle();
    checks++;
    if (s_ovf !== 1'b1 || s_rv !== 1'b1 || s_rdd !== 8'hB0 ||
        s_cnt !== 3'd3) begin
      failures++;
      $display("FAIL std_full_rdwr: got ovf=%b v=%b d=%h cnt=%0d want 1 1 b0 3",
               s_ovf, s_rv, s_rdd, s_cnt);
    end
    checks++;
    if (f_ovf !== 1'b1 || f_rv !== 1'b1 || f_rdd !== 8'hC1 ||
        f_cnt !== 3'd4) begin
      failures++;
      $display("FAIL fwft_full_rdwr: got ovf=%b v=%b d=%h cnt=%0d want 1 1 c1 4",
               f_ovf, f_rv, f_rdd, f_cnt);
    end
    for (int i = 0; i < 12; i++) begin
      if (sq.size() == 0 && !fm_v) break;
      s_rd = 1; f_rd = 1;
      tick();
      checks++;
      if (s_vec !== exp_std() || f_vec !== exp_fwft()) begin
        failures++;
        $display("FAIL drain%0d: got %h/%h want %h/%h",
                 i, s_vec, f_vec, exp_std(), exp_fwft());
      end
    end
    idle();
    tick();
    checks++;
    if (s_cnt !== 3'd0 || f_cnt !== 3'd0 ||
        s_empty !== 1'b1 || f_empty !== 1'b1) begin
      failures++;
      $display("FAIL drain_done: got cnt=%0d/%0d empty=%b/%b want 0/0 1/1",
               s_cnt, f_cnt, s_empty, f_empty);
    end
  endtask

  task automatic test_wrap();
    int sn, fnum;
    for (int c = 0; c < 1000; c++) begin
      sn   = sq.size();
      fnum = fq.size() + int'(fm_v);
      s_wr = ($urandom_range(0, 99) < ((sn <= 2) ? 65 : 35));
      s_rd = ($urandom_range(0, 99) < ((sn <= 2) ? 35 : 65));
      f_wr = ($urandom_range(0, 99) < ((fnum <= 2) ? 65 : 35));
      f_rd = ($urandom_range(0, 99) < ((fnum <= 2) ? 35 : 65));
      s_wd = 8'($urandom);
      f_wd = 8'($urandom);
      tick();
      checks++;
      if (s_vec !== exp_std()) begin
        failures++;
        $display("FAIL wrap_std@%0d: got %h want %h",
                 c, s_vec, exp_std());
      end
      checks++;
      if (f_vec !== exp_fwft()) begin
        failures++;
        $display("FAIL wrap_fwft@%0d: got %h want %h",
                 c, f_vec, exp_fwft());
      end
    end
    s_wr = 1; s_wd = 8'h77;
    f_wr = 1; f_wd = 8'h77;
    tick();
    rst = 1;
    s_wr = 1; s_rd = 1; f_wr = 1; f_rd = 1;
    tick();
    rst = 0;
    idle();
    checks++;
    if (s_vec !== RST_VEC || f_vec !== RST_VEC) begin
      failures++;
      $display("FAIL mid_reset: got %h/%h want %h",
               s_vec, f_vec, RST_VEC);
    end
    tick();
    checks++;
    if (s_vec !== RST_VEC || f_vec !== RST_VEC) begin
      failures++;
      $display("FAIL post_reset_idle: got %h/%h want %h",
               s_vec, f_vec, RST_VEC);
    end
  endtask

  initial begin
    rst = 1;
    idle();
    s_wd = 8'h00;
    f_wd = 8'h00;
    @(negedge clk);
    test_reset();
    test_std_fill();
    test_std_underflow();
    test_fwft_single();
    test_fwft_fill();
    test_full_rdwr();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
